mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, number of WAIT cycles without bus_ack before the access aborts (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst==0 resets).
REQ-004 in_wreg_addr  input  5  destination register, from ex_mem output.
REQ-005 in_wreg_enable  input  1  register write enable, from ex_mem output.
REQ-006 in_wdata  input  32  ALU result, from ex_mem output.
REQ-007 in_mem_op  input  3  0=NONE, 1=LW, 2=LB, 3=LBU, 4=SW, 5=SB; 6 and 7 treated as NONE.
REQ-008 in_mem_addr  input  32  byte address of the access.
REQ-009 in_store_data  input  32  store operand.
REQ-010 bus_req, bus_we  output  1 each  data-bus request and write strobe.
REQ-011 bus_addr, bus_wdata  output  32 each  word-aligned address (bits[1:0]=0) and write data.
REQ-012 bus_sel  output  4  byte lanes, bit n = bits[8n+7:8n].
REQ-013 bus_ack  input  1  bus completion; bus_rdata  input  32  read data valid when bus_ack=1.
REQ-014 stallreq  output  1  pipeline stall request; 1 holds ex_mem and upstream stages.
REQ-015 out_wreg_addr, out_wreg_enable, out_wdata  output  5/1/32  result to mem_wb.
REQ-016 bus_err, misalign_exc  output  1 each  one-cycle error pulses.

Function
REQ-017 FSM states IDLE, WAIT, DONE; registered state, 8-bit timeout counter, 32-bit load-data capture register.
REQ-018 IDLE: in_mem_op != NONE (and not misaligned per REQ-031) -> WAIT, counter cleared; else remain IDLE.
REQ-019 WAIT: bus_req=1, bus_addr/bus_we/bus_sel/bus_wdata from held inputs; bus_ack sampled 1 -> capture bus_rdata, go DONE.
REQ-020 WAIT: no ack -> counter+1; counter reaching ACK_TIMEOUT -> DONE with error flag set, capture register loaded 0.
REQ-021 bus_ack and timeout in the same cycle: ack wins, no error.
REQ-022 DONE -> IDLE unconditionally after one cycle; no new bus request issued in DONE.
REQ-023 stallreq = (IDLE and memory op pending) or WAIT; combinational; 0 in DONE; minimum access = 3 cycles, stall = 2+wait cycles.
REQ-024 bus_req, bus_we, bus_sel = 0 outside WAIT.
REQ-025 Passthrough: out_wreg_addr = in_wreg_addr always; for NONE/stores, out_wdata = in_wdata, out_wreg_enable = in_wreg_enable.
REQ-026 Loads in DONE: LW word; LB sign-extends byte addr[1:0] (little-endian lanes); LBU zero-extends; out_wreg_enable = in_wreg_enable.
REQ-027 Loads outside DONE: out_wreg_enable=0 so no partial result is committed.
REQ-028 SW: bus_sel=4'hF, bus_wdata=in_store_data; SB: bus_sel=1<<addr[1:0], bus_wdata=store byte replicated x4.
REQ-029 Timed-out access: bus_err=1 during DONE, out_wreg_enable=0, out_wdata=0.

Reset
REQ-030 rst low: immediately state=IDLE, counter=0, capture=0, bus_req=0, stallreq=0, bus_err=0, misalign_exc=0, mid-access included; outstanding ack after release ignored in IDLE.

Configuration
REQ-031 MEM_ACCESS_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]!=0 issue no bus access, stay IDLE, stallreq=0, misalign_exc=1 that cycle, out_wreg_enable=0.
REQ-032 MEM_ACCESS_ALIGN_CHECK_EN undefined: word addr[1:0] ignored (bus_addr forced aligned), misalign_exc tied 0; port list identical.

Verification
REQ-033 LW addr 0x100, ack on 1st WAIT cycle, rdata 0xDEADBEEF -> stallreq 2 cycles, DONE out_wdata=0xDEADBEEF, out_wreg_enable=1.
REQ-034 LB addr 0x103, rdata 0x80112233 -> out_wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SB addr 0x202, store_data 0x000000AB -> bus_sel=4'b0100, bus_wdata=0xABABABAB, bus_we=1, out_wreg_enable=0.
REQ-036 ACK_TIMEOUT=4, no ack -> 4 WAIT cycles, DONE with bus_err=1, out_wdata=0; ack on 4th cycle -> no error.
REQ-037 rst low in WAIT -> same cycle bus_req=0, stallreq=0; after release IDLE with NONE op, outputs pass through.
REQ-038 LW addr 0x101: with MEM_ACCESS_ALIGN_CHECK_EN misalign_exc=1, no bus_req; without it bus_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage data-bus access controller: IDLE/WAIT/DONE handshake, load formatting, ack timeout.
// Optional build macro MEM_ACCESS_ALIGN_CHECK_EN traps misaligned LW/SW instead of forcing alignment.
module mem_access #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_wreg_addr,
    input  logic        in_wreg_enable,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_mem_op,
    input  logic [31:0] in_mem_addr,
    input  logic [31:0] in_store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stallreq,
    output logic [4:0]  out_wreg_addr,
    output logic        out_wreg_enable,
    output logic [31:0] out_wdata,
    output logic        bus_err,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d;
    logic        err_q, err_d;

    logic        is_lw, is_lb, is_lbu, is_sw, is_sb;
    logic        is_load, is_store, is_word, misaligned;
    logic [7:0]  load_byte;
    logic [31:0] load_result;

    assign is_lw    = (in_mem_op == OP_LW);
    assign is_lb    = (in_mem_op == OP_LB);
    assign is_lbu   = (in_mem_op == OP_LBU);
    assign is_sw    = (in_mem_op == OP_SW);
    assign is_sb    = (in_mem_op == OP_SB);
    assign is_load  = is_lw | is_lb | is_lbu;
    assign is_store = is_sw | is_sb;
    assign is_word  = is_lw | is_sw;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = is_word && (in_mem_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Little-endian lane pick from the captured word; the address is held stable by the stall.
    assign load_byte   = cap_q[{in_mem_addr[1:0], 3'b000} +: 8];
    assign load_result = is_lw ? cap_q :
                         is_lb ? {{24{load_byte[7]}}, load_byte} : {24'h0, load_byte};

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        cap_d           = cap_q;
        err_d           = err_q;
        bus_req         = 1'b0;
        bus_we          = 1'b0;
        bus_sel         = 4'h0;
        bus_addr        = 32'h0;
        bus_wdata       = 32'h0;
        stallreq        = 1'b0;
        bus_err         = 1'b0;
        misalign_exc    = 1'b0;
        out_wreg_addr   = in_wreg_addr;
        out_wreg_enable = is_load ? 1'b0 : in_wreg_enable;
        out_wdata       = in_wdata;

        unique case (state_q)
            S_IDLE: begin
                if ((is_load || is_store) && !misaligned) begin
                    state_d  = S_WAIT;
                    cnt_d    = 8'd0;
                    err_d    = 1'b0;
                    stallreq = 1'b1;
                end
                if (misaligned) begin
                    misalign_exc    = 1'b1;
                    out_wreg_enable = 1'b0;
                end
            end
            S_WAIT: begin
                bus_req   = 1'b1;
                bus_we    = is_store;
                bus_addr  = {in_mem_addr[31:2], 2'b00};
                bus_sel   = is_word ? 4'hF : 4'(4'b0001 << in_mem_addr[1:0]);
                bus_wdata = is_sb ? {4{in_store_data[7:0]}} : in_store_data;
                stallreq  = 1'b1;
                if (bus_ack) begin
                    cap_d   = bus_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT) begin
                        cap_d   = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                bus_err = err_q;
                if (err_q) begin
                    out_wreg_enable = 1'b0;
                    out_wdata       = 32'h0;
                end else if (is_load) begin
                    out_wreg_enable = in_wreg_enable;
                    out_wdata       = load_result;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset must silence the stall and pulses at once, even with an op still presented.
        if (!rst) begin
            stallreq     = 1'b0;
            bus_err      = 1'b0;
            misalign_exc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cap_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

endmodule
